dcache_fsm: RTL and testbench

Control sequencer for the 4-way write-back data cache. Sits between the core's load/store stage, the cache array, and the memory-side handshake unit. It decides per access whether the cache serves it directly, writes back a dirty victim, or fills a line, and it asserts the cache's write/fill enables. It also stalls the core until the access completes and keeps hit/miss/write-back statistics.

---
 rtl/dcache_fsm.sv | 135 +++++++++++++
 tb/tb_dcache_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_fsm.sv
// Access sequencer for the 4-way write-back data cache: serves hits, writes back
// dirty victims, fills lines, stalls the core and keeps hit/miss/write-back counts.
module dcache_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_arstn,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic                 i_store_ma,
    input  logic                 i_hit,
    input  logic                 i_dirty,
    input  logic                 i_mem_done,
    output logic                 o_stall,
    output logic                 o_cache_we,
    output logic                 o_block_we,
    output logic                 o_mem_access,
    output logic                 o_mem_rd_req,
    output logic                 o_mem_wr_req,
    output logic                 o_addr_wb_sel,
    output logic [CNT_WIDTH-1:0] o_hit_cnt,
    output logic [CNT_WIDTH-1:0] o_miss_cnt,
    output logic [CNT_WIDTH-1:0] o_wb_cnt
);

    // state        | meaning
    // ST_IDLE      | serve hits, detect misses
    // ST_WRITEBACK | dirty victim being written to memory
    // ST_ALLOCATE  | line fill from memory in progress
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic stall;
    logic cache_we;
    logic block_we;
    logic mem_access;
    logic mem_rd_req;
    logic mem_wr_req;
    logic addr_wb_sel;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        cache_we    = 1'b0;
        block_we    = 1'b0;
        mem_access  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        addr_wb_sel = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        wb_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // misaligned stores are dropped here; the exception is raised downstream
                if (i_req && !(i_we && i_store_ma)) begin
                    if (i_hit) begin
                        mem_access = 1'b1;
                        cache_we   = i_we;
                        hit_inc    = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = i_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                stall       = 1'b1;
                mem_wr_req  = 1'b1;
                addr_wb_sel = 1'b1;
                if (i_mem_done) begin
                    wb_inc  = 1'b1;
                    state_d = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                if (i_mem_done) begin
                    block_we = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Mealy outputs follow i_req even while reset holds the state, so gate them.
    assign o_stall       = i_arstn & stall;
    assign o_cache_we    = i_arstn & cache_we;
    assign o_block_we    = i_arstn & block_we;
    assign o_mem_access  = i_arstn & mem_access;
    assign o_mem_rd_req  = i_arstn & mem_rd_req;
    assign o_mem_wr_req  = i_arstn & mem_wr_req;
    assign o_addr_wb_sel = i_arstn & addr_wb_sel;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
            o_wb_cnt   <= '0;
        end else begin
            if (hit_inc) begin
                o_hit_cnt <= o_hit_cnt + CNT_WIDTH'(1);
            end
            if (miss_inc) begin
                o_miss_cnt <= o_miss_cnt + CNT_WIDTH'(1);
            end
            if (wb_inc) begin
                o_wb_cnt <= o_wb_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dcache_fsm.sv
// Directed bench for dcache_fsm: reset, hits, clean/dirty misses, misaligned stores,
// reset during a fill, and counter wrap on a narrow-counter instance.
module tb_dcache_fsm;

    logic clk;
    logic arstn;
    logic arstn4;
    logic req;
    logic we;
    logic ma;
    logic hit;
    logic dirty;
    logic done;

    logic        stall, cache_we, block_we, mem_access, rd_req, wr_req, wb_sel;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
    logic        d4_stall, d4_cache_we, d4_block_we, d4_mem_access, d4_rd_req, d4_wr_req, d4_wb_sel;
    logic [3:0]  d4_hit_cnt, d4_miss_cnt, d4_wb_cnt;

    // {stall, cache_we, block_we, mem_access, rd_req, wr_req, wb_sel}
    logic [6:0] outs;
    assign outs = {stall, cache_we, block_we, mem_access, rd_req, wr_req, wb_sel};

    int checks   = 0;
    int failures = 0;
    int exp_hit  = 0;
    int exp_miss = 0;
    int exp_wb   = 0;

    dcache_fsm #(.CNT_WIDTH(32)) u_dut (
        .i_clk(clk), .i_arstn(arstn), .i_req(req), .i_we(we), .i_store_ma(ma),
        .i_hit(hit), .i_dirty(dirty), .i_mem_done(done),
        .o_stall(stall), .o_cache_we(cache_we), .o_block_we(block_we),
        .o_mem_access(mem_access), .o_mem_rd_req(rd_req), .o_mem_wr_req(wr_req),
        .o_addr_wb_sel(wb_sel), .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt), .o_wb_cnt(wb_cnt)
    );

    dcache_fsm #(.CNT_WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_arstn(arstn4), .i_req(req), .i_we(we), .i_store_ma(ma),
        .i_hit(hit), .i_dirty(dirty), .i_mem_done(done),
        .o_stall(d4_stall), .o_cache_we(d4_cache_we), .o_block_we(d4_block_we),
        .o_mem_access(d4_mem_access), .o_mem_rd_req(d4_rd_req), .o_mem_wr_req(d4_wr_req),
        .o_addr_wb_sel(d4_wb_sel), .o_hit_cnt(d4_hit_cnt), .o_miss_cnt(d4_miss_cnt),
        .o_wb_cnt(d4_wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic w, input logic m, input logic h,
                         input logic d, input logic dn);
        req = r; we = w; ma = m; hit = h; dirty = d; done = dn;
    endtask

    task automatic test_reset;
        arstn = 1'b0;
        arstn4 = 1'b0;
        drive(1, 1, 0, 1, 0, 0);
        @(negedge clk); #1;
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b want=%b", outs, 7'b0);
        end
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== 96'd0) begin
            failures++;
            $display("FAIL reset_cnts got=%0d/%0d/%0d want=0/0/0", hit_cnt, miss_cnt, wb_cnt);
        end
        arstn = 1'b1;
        #1;
        checks++;
        if (outs !== 7'b0101000) begin
            failures++;
            $display("FAIL reset_first_hit got=%b want=%b", outs, 7'b0101000);
        end
        exp_hit = 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (hit_cnt !== 32'(exp_hit)) begin
            failures++;
            $display("FAIL reset_hit_cnt got=%0d want=%0d", hit_cnt, exp_hit);
        end
    endtask

    task automatic test_clean_miss;
        int rd_cycles;
        int blk_cycles;
        int blk_idx;
        rd_cycles = 0; blk_cycles = 0; blk_idx = -1;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 7'b1000000) begin
            failures++;
            $display("FAIL clean_req_cycle got=%b want=%b", outs, 7'b1000000);
        end
        exp_miss++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done = (i == 5);
            #1;
            if (rd_req === 1'b1) rd_cycles++;
            if (block_we === 1'b1) begin
                blk_cycles++;
                blk_idx = i;
            end
            checks++;
            if (stall !== 1'b1) begin
                failures++;
                $display("FAIL clean_stall cycle=%0d got=%b want=1", i, stall);
            end
        end
        checks++;
        if (rd_cycles != 6) begin
            failures++;
            $display("FAIL clean_rd_len got=%0d want=6", rd_cycles);
        end
        checks++;
        if (blk_cycles != 1 || blk_idx != 5) begin
            failures++;
            $display("FAIL clean_block_we got=%0d@%0d want=1@5", blk_cycles, blk_idx);
        end
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (outs !== 7'b0001000) begin
            failures++;
            $display("FAIL clean_rehit got=%b want=%b", outs, 7'b0001000);
        end
        exp_hit++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss) || wb_cnt !== 32'(exp_wb)) begin
            failures++;
            $display("FAIL clean_cnts got=%0d/%0d/%0d want=%0d/%0d/%0d",
                     hit_cnt, miss_cnt, wb_cnt, exp_hit, exp_miss, exp_wb);
        end
    endtask

    task automatic test_dirty_store_miss;
        logic [6:0] want;
        @(negedge clk);
        drive(1, 1, 0, 0, 1, 0);
        #1;
        checks++;
        if (outs !== 7'b1000000) begin
            failures++;
            $display("FAIL dirty_req_cycle got=%b want=%b", outs, 7'b1000000);
        end
        exp_miss++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            done = (i == 2);
            #1;
            checks++;
            if (outs !== 7'b1000011) begin
                failures++;
                $display("FAIL dirty_wb cycle=%0d got=%b want=%b", i, outs, 7'b1000011);
            end
        end
        exp_wb++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            done = (i == 3);
            #1;
            want = (i == 3) ? 7'b1010100 : 7'b1000100;
            checks++;
            if (outs !== want) begin
                failures++;
                $display("FAIL dirty_fill cycle=%0d got=%b want=%b", i, outs, want);
            end
        end
        @(negedge clk);
        drive(1, 1, 0, 1, 0, 0);
        #1;
        checks++;
        if (outs !== 7'b0101000) begin
            failures++;
            $display("FAIL dirty_rehit got=%b want=%b", outs, 7'b0101000);
        end
        exp_hit++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss) || wb_cnt !== 32'(exp_wb)) begin
            failures++;
            $display("FAIL dirty_cnts got=%0d/%0d/%0d want=%0d/%0d/%0d",
                     hit_cnt, miss_cnt, wb_cnt, exp_hit, exp_miss, exp_wb);
        end
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        drive(1, 1, 1, 1, 0, 0);
        #1;
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL ma_hit got=%b want=%b", outs, 7'b0);
        end
        @(negedge clk);
        drive(1, 1, 1, 0, 1, 0);
        #1;
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL ma_miss got=%b want=%b", outs, 7'b0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL ma_state got=%b want=%b", outs, 7'b0);
        end
        checks++;
        if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss) || wb_cnt !== 32'(exp_wb)) begin
            failures++;
            $display("FAIL ma_cnts got=%0d/%0d/%0d want=%0d/%0d/%0d",
                     hit_cnt, miss_cnt, wb_cnt, exp_hit, exp_miss, exp_wb);
        end
    endtask

    task automatic test_reset_mid_alloc;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 7'b1000100) begin
            failures++;
            $display("FAIL rst_alloc_pre got=%b want=%b", outs, 7'b1000100);
        end
        #1;
        arstn = 1'b0;
        #1;
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL rst_alloc_async got=%b want=%b", outs, 7'b0);
        end
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== 96'd0) begin
            failures++;
            $display("FAIL rst_alloc_cnts got=%0d/%0d/%0d want=0/0/0", hit_cnt, miss_cnt, wb_cnt);
        end
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        arstn = 1'b1;
        @(negedge clk);
        done = 1'b1;
        #1;
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL rst_stray_done got=%b want=%b", outs, 7'b0);
        end
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (outs !== 7'b0001000) begin
            failures++;
            $display("FAIL rst_idle_hit got=%b want=%b", outs, 7'b0001000);
        end
        exp_hit++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
            failures++;
            $display("FAIL rst_post_cnts got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        arstn4 = 1'b1;
        drive(1, 0, 0, 1, 0, 0);
        repeat (17) @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        exp_hit += 17;
        #1;
        checks++;
        if (d4_hit_cnt !== 4'd1) begin
            failures++;
            $display("FAIL wrap_hit_cnt got=%0d want=1", d4_hit_cnt);
        end
        checks++;
        if (hit_cnt !== 32'(exp_hit)) begin
            failures++;
            $display("FAIL b2b_hit_cnt got=%0d want=%0d", hit_cnt, exp_hit);
        end
        checks++;
        if (d4_miss_cnt !== 4'd0 || d4_stall !== 1'b0) begin
            failures++;
            $display("FAIL wrap_misc got=%0d/%b want=0/0", d4_miss_cnt, d4_stall);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_store_miss();
        test_misaligned();
        test_reset_mid_alloc();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
